// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: state encoding and
// default sizing.
package div_pkg;

    // Default operand width and iteration counter width (must hold DIV_WIDTH).
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    // Handshake levels as seen on start_i and ready_o.
    localparam logic DIV_START           = 1'b1;
    localparam logic DIV_STOP            = 1'b0;
    localparam logic DIV_RESULT_READY    = 1'b1;
    localparam logic DIV_RESULT_NOTREADY = 1'b0;

    // Divider control states.
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

endpackage

// File: rtl/div.sv
// Multi-cycle integer divider for DIV/DIVU. Restoring shift-subtract, one
// quotient bit per clock. Returns {remainder, quotient} with ready_o and
// holds it until the requester drops start_i.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_e state_q, state_d;

    // Working register: remainder accumulates in [2W:W+1], quotient in [W-1:0].
    logic [2*WIDTH:0]   work_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_quot_q;
    logic               neg_rem_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    // Control strobes decoded from the current state.
    logic load, step, fixup, abort, drop, hold, zero;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quot_raw, rem_raw, quot_fix, rem_fix;

    // Operand magnitudes for loading, the trial subtraction and the sign fix-up.
    always_comb begin
        dividend_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        divisor_abs  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        diff         = {1'b0, work_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};
        quot_raw     = work_q[WIDTH-1:0];
        rem_raw      = work_q[2*WIDTH:WIDTH+1];
        quot_fix     = neg_quot_q ? -quot_raw : quot_raw;
        rem_fix      = neg_rem_q ? -rem_raw : rem_raw;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= DIV_FREE;
        else     state_q <= state_d;
    end

    // Next-state and control strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise
        // any path that skips an assignment infers a latch.
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fixup   = 1'b0;
        abort   = 1'b0;
        drop    = 1'b0;
        hold    = 1'b0;
        zero    = 1'b0;
        unique case (state_q)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    load    = 1'b1;
                    state_d = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                zero    = 1'b1;
                state_d = DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    abort   = 1'b1;
                    state_d = DIV_FREE;
                end else if (cnt_q != CNT_W'(WIDTH)) begin
                    step = 1'b1;
                end else begin
                    fixup   = 1'b1;
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    drop    = 1'b1;
                    state_d = DIV_FREE;
                end else begin
                    hold = 1'b1;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and output registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the datapath is reset along with the FSM so that result_o
        // clears immediately on rst, even mid-operation.
        if (rst) begin
            work_q     <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOTREADY;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            if (load) begin
                work_q     <= {{WIDTH{1'b0}}, dividend_abs, 1'b0};
                divisor_q  <= divisor_abs;
                cnt_q      <= '0;
                neg_quot_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                neg_rem_q  <= signed_div_i & opdata1_i[WIDTH-1];
            end
            if (step) begin
                work_q <= diff[WIDTH] ? {work_q[2*WIDTH-1:0], 1'b0}
                                      : {diff[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (abort) begin
                cnt_q    <= '0;
                result_q <= '0;
                ready_q  <= DIV_RESULT_NOTREADY;
            end
            if (zero) begin
                result_q <= '0;
            end
            if (fixup) begin
                cnt_q    <= '0;
                result_q <= {rem_fix, quot_fix};
                ready_q  <= DIV_RESULT_READY;
            end
            if (hold) begin
                ready_q <= DIV_RESULT_READY;
            end
            if (drop) begin
                result_q <= '0;
                ready_q  <= DIV_RESULT_NOTREADY;
            end
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the multi-cycle divider: directed cases, latency,
// annul, async reset and randomized operands against a scoreboard queue.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1, opdata2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return 64'd0;
        ma = (sgn && a[31]) ? (32'd0 - a) : a;
        mb = (sgn && b[31]) ? (32'd0 - b) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
        if (sgn && a[31])           r = 32'd0 - r;
        return {r, q};
    endfunction

    // Issue one request, wait for ready, check latency and result, hold
    // start for extra cycles, then release and check the outputs clear.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                          input int hold, input bit scramble);
        int          cyc;
        logic [63:0] want;
        @(negedge clk);
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        exp_q.push_back(exp);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (scramble && cyc == 5) begin
                opdata1    = $urandom;
                opdata2    = $urandom;
                signed_div = ~signed_div;
            end
        end while (!ready && cyc < 100);
        want = exp_q.pop_front();
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " result"}, result, want);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " held ready"}, 64'(ready), 64'd1);
        end
        if (hold > 0) check({tag, " held result"}, result, want);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " released ready"}, 64'(ready), 64'd0);
        check({tag, " released result"}, result, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        int seen;
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;

        // Reset state before any clock edge.
        #3;
        check("reset ready", 64'(ready), 64'd0);
        check("reset result", result, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op("divu 100/7",      1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34, 2, 1'b0);
        run_op("div -7/2",        1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 34, 0, 1'b0);
        run_op("div min/-1",      1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 34, 0, 1'b0);
        run_op("divu max/1",      1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 34, 0, 1'b0);
        run_op("divu 3/7",        1'b0, 32'd3,          32'd7,          64'h00000003_00000000, 34, 0, 1'b0);
        run_op("div 7/-2",        1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 34, 0, 1'b0);
        run_op("divu max/max",    1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 34, 0, 1'b0);
        run_op("divu 5/0",        1'b0, 32'd5,          32'd0,          64'd0,                  3, 5, 1'b0);
        run_op("div -9/0",        1'b1, 32'hFFFFFFF7,   32'd0,          64'd0,                  3, 0, 1'b0);

        // annul together with start in DivFree: request not accepted, even a divide-by-zero.
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd5;
        opdata2    = 32'd0;
        start      = 1'b1;
        annul      = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1;
        end
        check("annul in free no ready", 64'(seen), 64'd0);
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;

        // annul pulsed at cycle 10 of DivOn.
        @(negedge clk);
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        start   = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        check("annul ready", 64'(ready), 64'd0);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1;
        end
        check("annul never ready", 64'(seen), 64'd0);
        run_op("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 0, 1'b0);

        // Async reset mid-DivOn, between clock edges.
        @(negedge clk);
        opdata1 = 32'd1000;
        opdata2 = 32'd10;
        start   = 1'b1;
        repeat (15) @(posedge clk);
        #3;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check("rst mid-on ready", 64'(ready), 64'd0);
        check("rst mid-on result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("divu 1000/10 after rst", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 34, 0, 1'b0);

        // Async reset while a result is being presented.
        @(negedge clk);
        opdata1 = 32'd50;
        opdata2 = 32'd8;
        start   = 1'b1;
        seen    = 0;
        while (!ready && seen < 100) begin
            @(posedge clk);
            #1;
            seen++;
        end
        check("pre-rst result", result, 64'h00000002_00000006);
        #2;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check("rst in end ready", 64'(ready), 64'd0);
        check("rst in end result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized operands, some with operands scrambled mid-operation.
        for (int i = 0; i < 10; i++) begin
            logic        sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom_range(1));
            a   = $urandom;
            b   = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (b == 32'd0) b = 32'd3;
            if (i % 4 == 1) a = 32'h80000000;
            run_op("random", sgn, a, b, model(sgn, a, b), 34, 0, (i % 2) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit integer divider serving as responder to the EX stage for DIV/DIVU.
- EX initiates with start_i plus operands and holds them stable; the divider returns {remainder, quotient} with ready_o.
- EX forwards the result to HI/LO through its existing whilo_o/hi_o/lo_o path.
- Restoring shift-subtract algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high (RstEnable).
- signed_div_i  input  1  1 = DIV (two's-complement), 0 = DIVU.
- opdata1_i  input  WIDTH  dividend; held stable by EX while start_i is high.
- opdata2_i  input  WIDTH  divisor; held stable by EX while start_i is high.
- start_i  input  1  request; held high by EX until ready_o is seen.
- annul_i  input  1  cancel in-flight division (flush or exception).
- result_o  output  2*WIDTH  [63:32] remainder (to HI), [31:0] quotient (to LO).
- ready_o  output  1  result valid.

Behaviour:
- Reset: async, rst=1. state=DivFree, cnt=0, ready_o=0, result_o=0. The same values apply if rst asserts mid-operation.
- All outputs are registered.
- State DivFree:
  - Requires start_i=1 and annul_i=0 to accept a request; otherwise stays in DivFree.
  - If opdata2_i==0 -> DivByZero.
  - Otherwise -> DivOn with cnt=0.
  - Working operands are loaded on the accepting edge. When signed_div_i=1, each operand with bit31 set is replaced by its two's-complement magnitude; when signed_div_i=0, operands are taken as-is.
  - Working register is 2*WIDTH+1 bits, initialised to {32'b0, |dividend|, 1'b0}.
  - ready_o=0 and result_o=0 while in DivFree.
- State DivByZero:
  - On the next edge, result_o=0 and state -> DivEnd.
  - There is no exception output; MIPS leaves the result undefined.
- State DivOn:
  - If annul_i=1 -> DivFree, cnt=0, no result produced. This takes priority over the step.
  - Else, while cnt!=WIDTH, perform one step per edge and increment cnt:
    - Compute 33-bit diff = upper half minus {0, divisor}.
    - If diff is negative, shift the working register left with quotient bit 0.
    - Otherwise, load the upper half with diff[31:0], shift, and set quotient bit 1.
  - When cnt==WIDTH, apply sign fix-up and go to DivEnd:
    - Signed only: negate the quotient if the dividend and divisor signs differ.
    - Signed only: negate the remainder if the dividend is negative.
    - Register result_o={rem, quot} and set ready_o=1.
- State DivEnd:
  - ready_o=1 and result_o is held.
  - When start_i=0 -> DivFree, ready_o=0, result_o=0.
  - While start_i stays 1, remain in DivEnd. A new request must see start_i drop for at least one cycle.
- Latency, counting the accepting edge as edge 1:
  - Normal: ready_o goes high after edge 34 (1 load + 32 steps + 1 fix-up).
  - Divide-by-zero: ready_o goes high after edge 3 (DivFree -> DivByZero -> DivEnd).
- annul_i:
  - Ignored in DivEnd; EX drops start_i to release the divider.
  - annul_i together with start_i in DivFree means the request is not accepted.
- Arithmetic:
  - 0x80000000 / 0xFFFFFFFF signed wraps to quotient 0x80000000, remainder 0, with no trap.
  - All arithmetic is modulo 2^32.
- Operand changes while in DivOn are ignored; the divider works only from its internal copies.

Decomposition:
- Add to defines.v:
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivResultReady 1'b1, DivResultNotReady 1'b0.
  - DivStart 1'b1, DivStop 1'b0.
  - DivCntBus 5:0 (or 6-bit counter width).
  - EXE_DIV_OP and EXE_DIVU_OP.
- No sub-module; the single step is a combinational subtractor inside div.
- EX gains a stall request plus the div_* ports in a separate change.

Test Plan:
- DIVU 100/7, start held -> ready_o high exactly 34 cycles after acceptance; result_o=0x00000002_0000000E. After start_i drops, ready_o=0 and result_o=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3).
- DIV 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000. DIVU 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
- DIVU 5/0 -> ready_o high 3 cycles after acceptance, result_o=0. Holding start_i for 5 extra cycles keeps ready_o=1 and state DivEnd.
- annul_i pulsed at cycle 10 of DIVU 100/7 -> state DivFree next edge, ready_o never rises. A new DIVU 9/3 then yields 0x00000000_00000003.
- rst asserted asynchronously mid-DivOn -> ready_o=0 and result_o=0 immediately, without a clock edge. After release, the next request completes normally.
